// File: rtl/vending_machine.sv
// Coin-operated vending controller: accumulates i/j coin credit toward PRICE,
// pulses X on purchase and Y when I_VAL units of excess are refunded.
module vending_machine #(
  parameter int I_VAL = 1,
  parameter int J_VAL = 2,
  parameter int PRICE = 3,
  localparam int CW   = $clog2(PRICE + I_VAL + J_VAL) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic j,
  output logic X,
  output logic Y
);

  if (!(I_VAL >= 1 && I_VAL <= J_VAL && J_VAL <= PRICE)) begin : g_bad_params
    $error("vending_machine: need 1 <= I_VAL <= J_VAL <= PRICE");
  end

  localparam logic [CW-1:0] IV = CW'(I_VAL);
  localparam logic [CW-1:0] JV = CW'(J_VAL);
  localparam logic [CW-1:0] PV = CW'(PRICE);

  logic [CW-1:0] credit, credit_nxt;
  logic [CW-1:0] deposit, total, excess;
  logic          x_nxt, y_nxt;

  always_comb begin
    deposit    = (i ? IV : '0) + (j ? JV : '0);
    total      = credit + deposit;
    excess     = '0;
    x_nxt      = 1'b0;
    y_nxt      = 1'b0;
    credit_nxt = total;
    if (total >= PV) begin
      x_nxt      = 1'b1;
      excess     = total - PV;
      credit_nxt = '0;
      if (excess != '0) begin
        // One I_VAL coin goes back; anything beyond that is carried as credit.
        y_nxt      = 1'b1;
        credit_nxt = (excess >= IV) ? excess - IV : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
      X      <= 1'b0;
      Y      <= 1'b0;
    end else begin
      credit <= credit_nxt;
      X      <= x_nxt;
      Y      <= y_nxt;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine with default parameters; credit is
// observed through the internal register.
module tb_vending_machine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i = 1'b0;
  logic j = 1'b0;
  logic X, Y;
  int   checks = 0;
  int   failures = 0;

  vending_machine dut (.clk(clk), .rst(rst), .i(i), .j(j), .X(X), .Y(Y));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present coins for one edge, then sample 1 time unit after it.
  task automatic cyc(input logic ii, input logic jj);
    i = ii; j = jj;
    @(posedge clk); #1;
  endtask

  task automatic expect3(input string tag, input int ex, input int ey, input int ec);
    chk({tag, ".X"}, int'(X), ex);
    chk({tag, ".Y"}, int'(Y), ey);
    chk({tag, ".credit"}, int'(dut.credit), ec);
  endtask

  initial begin
    // Reset held with random coin activity
    for (int k = 0; k < 6; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      expect3("rst_hold", 0, 0, 0);
    end
    rst = 1'b1;
    cyc(0, 0); expect3("idle0", 0, 0, 0);
    cyc(0, 0); expect3("idle1", 0, 0, 0);

    // Exact payment with three small coins
    cyc(1, 0); expect3("iii_1", 0, 0, 1);
    cyc(1, 0); expect3("iii_2", 0, 0, 2);
    cyc(1, 0); expect3("iii_3", 1, 0, 0);
    cyc(0, 0); expect3("iii_after", 0, 0, 0);

    // Mixed sequence
    cyc(0, 0); expect3("mix_idle", 0, 0, 0);
    cyc(0, 1); expect3("mix_j", 0, 0, 2);
    cyc(1, 1); expect3("mix_ij_a", 1, 1, 1);
    cyc(1, 0); expect3("mix_i", 0, 0, 2);
    cyc(1, 1); expect3("mix_ij_b", 1, 1, 1);
    cyc(0, 0); expect3("hold_1a", 0, 0, 1);
    cyc(0, 0); expect3("hold_1b", 0, 0, 1);
    cyc(0, 1); expect3("c1_plus_j", 1, 0, 0);

    // Overpay with two large coins
    cyc(0, 1); expect3("jj_1", 0, 0, 2);
    cyc(0, 1); expect3("jj_2", 1, 1, 0);

    // Exact with mixes
    cyc(1, 0); expect3("ij_seq_1", 0, 0, 1);
    cyc(0, 1); expect3("ij_seq_2", 1, 0, 0);
    cyc(1, 1); expect3("ij_same", 1, 0, 0);
    cyc(0, 1); expect3("ji_seq_1", 0, 0, 2);
    cyc(1, 0); expect3("ji_seq_2", 1, 0, 0);

    // Async reset while X/Y are high and credit is carried
    cyc(0, 1); expect3("ar_pre_j", 0, 0, 2);
    cyc(1, 1); expect3("ar_pre_ij", 1, 1, 1);
    i = 1'b0; j = 1'b0;
    #2 rst = 1'b0;
    #1 expect3("ar_async", 0, 0, 0);
    @(posedge clk); #1;
    expect3("ar_held", 0, 0, 0);
    rst = 1'b1;
    cyc(1, 0); expect3("ar_post_i", 0, 0, 1);
    cyc(0, 0); expect3("ar_post_idle", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
